path_trace_buffer: RTL
======================

# path_trace_buffer

Captures the stream of node indices emitted by the route-tracing controller while it walks the predecessor chain from destination back to source. Suppresses repeated indices and, when the trace completes, replays the stored path to the VGA drawing logic in source-to-destination order over a valid/ready handshake. Sits between the controller's predecessor-address and VGA-write outputs and the display module's node-index input.

## Interface

Parameters:
- NODE_W, 5: node index width; the graph has 2^NODE_W nodes.
- DEPTH, 32: maximum stored hops; must be a power of two and ≤ 2^NODE_W.
- CNT_W, $clog2(DEPTH)+1: derived localparam for the hop counter.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous clear. Empties the buffer and enters CAPTURE.
- wr_en, input, 1: node strobe from the controller.
- wr_node, input, NODE_W: node index written on wr_en.
- trace_done, input, 1: the controller has finished the chain. Level or pulse.
- rd_ready, input, 1: the display accepts rd_node this cycle.
- rd_valid, output, 1: rd_node holds a valid path entry.
- rd_node, output, NODE_W: path entry, in source-first order.
- rd_last, output, 1: qualifies the final entry (the destination).
- hop_count, output, CNT_W: number of stored entries.
- overflow, output, 1: sticky; a write was dropped because the buffer was full.
- loop_err, output, 1: sticky; a non-consecutive repeat was seen (only with the macro enabled).
- busy, output, 1: high in CAPTURE or REPLAY.

## Operation

States: IDLE, CAPTURE, REPLAY, HOLD. Reset enters IDLE.

- Any state, clr=1 → CAPTURE. This clears hop_count, overflow, loop_err, rd_valid and the seen-vector. clr has priority over every other input.
- IDLE: wr_en and trace_done are ignored.
- CAPTURE, wr_en=1:
  - If wr_node equals the last stored entry (and hop_count>0), the write is dropped silently. This covers the controller holding the source index for several cycles.
  - Otherwise, if hop_count==DEPTH, the write is dropped and overflow is set.
  - Otherwise, mem[hop_count] ← wr_node and hop_count increments.
- CAPTURE, trace_done=1 with no wr_en in the same cycle:
  - hop_count>0 → REPLAY.
  - hop_count==0 → HOLD.
- CAPTURE, wr_en and trace_done together: the write is processed first, then the transition is taken.
- REPLAY:
  - Read pointer starts at hop_count−1 and decrements, so output is reversed to source-first order.
  - An entry is transferred on rd_valid & rd_ready.
  - rd_last is asserted when the read pointer is 0.
  - Transfer of the last entry → HOLD.
  - wr_en is ignored.
- HOLD: rd_valid=0. hop_count and the flags are retained until clr.

Handshake rules:
- rd_node and rd_last are stable while rd_valid=1 and rd_ready=0.
- rd_valid is never deasserted without a transfer, except on clr or reset.

## Timing

Reset values: rd_valid=0, rd_node=0, rd_last=0, hop_count=0, overflow=0, loop_err=0, busy=0, state=IDLE.

- Write: hop_count reflects a write one cycle after the wr_en edge.
- Replay start: rd_valid rises on the first clock after entering REPLAY, i.e. 2 cycles after trace_done is sampled. rd_node is registered.
- Throughput: one entry per cycle while rd_ready stays high. A path of N entries drains in N cycles after the first valid.
- clr or reset mid-REPLAY: rd_valid is 0 on the next cycle (reset: immediately). No partial transfer is reported.
- Memory: register array, DEPTH×NODE_W, with no read-during-write hazard, because writes and reads occur in disjoint states.
- Overflow: the write that would create entry DEPTH+1 sets overflow in the same cycle hop_count would have incremented. hop_count saturates at DEPTH.

## Configuration

- PATH_TRACE_LOOP_CHECK_EN defined:
  - A 2^NODE_W-bit seen-vector is maintained and cleared on clr.
  - A CAPTURE write whose node is already seen and is not equal to the last entry is dropped and sets loop_err.
  - In this case, overflow is not set.
- Not defined: no seen-vector; such writes are stored normally; loop_err is tied to 0.

## Test plan

- Basic path: clr, then wr_node 9,4,2 with wr_en, then trace_done, with rd_ready=1. Expect rd_node 2,4,9 on consecutive cycles, rd_last only with 9, hop_count=3, then HOLD with busy=0.
- Duplicate suppression: writes 7,3,3,3,1 then trace_done. Expect hop_count=3 and replay 1,3,7.
- Backpressure: 3-entry path with rd_ready toggled 1,0,0,1,1. Expect rd_node held during the stall and exactly 3 transfers.
- Overflow, DEPTH=4: write 5 distinct nodes 1..5. Expect hop_count=4, overflow=1 and replay 4,3,2,1.
- Abort and empty:
  - clr asserted on the second replay cycle: rd_valid=0 on the next cycle and hop_count=0.
  - trace_done with no writes: HOLD reached, rd_valid never asserted.
- Macro on: writes 6,2,6. Expect loop_err=1, hop_count=2 and replay 2,6. Macro off: hop_count=3 and loop_err=0.

Source files
------------

// File: rtl/path_trace_buffer.sv
// rtl/path_trace_buffer.sv - captures a reversed route trace, drops repeats, replays it source-first
// Optional feature: PATH_TRACE_LOOP_CHECK_EN enables the seen-vector loop detector and loop_err.
module path_trace_buffer #(
    parameter int NODE_W = 5,
    parameter int DEPTH  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_node,
    input  logic              trace_done,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [NODE_W-1:0] rd_node,
    output logic              rd_last,
    output logic [CNT_W-1:0]  hop_count,
    output logic              overflow,
    output logic              loop_err,
    output logic              busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_REPLAY  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NODE_W-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0]   hop_q, hop_d;
    logic               ovf_q, ovf_d;
    logic               loop_q, loop_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic [NODE_W-1:0]  rd_node_q, rd_node_d;
    logic               rd_last_q, rd_last_d;

    logic [PTR_W-1:0]   last_idx;
    logic [PTR_W-1:0]   first_idx;
    logic [PTR_W-1:0]   next_idx;
    logic               is_dup;
    logic               is_full;
    logic               is_loop;
    logic               wr_accept;

    // When hop_q == DEPTH the low bits wrap to 0, so last_idx still lands on DEPTH-1.
    assign last_idx  = hop_q[PTR_W-1:0] - PTR_W'(1);
    assign first_idx = last_idx;
    assign next_idx  = rd_ptr_q - PTR_W'(1);
    assign is_dup    = (hop_q != '0) && (wr_node == mem_q[last_idx]);
    assign is_full   = (hop_q == CNT_W'(DEPTH));

`ifdef PATH_TRACE_LOOP_CHECK_EN
    localparam int NODES = 1 << NODE_W;
    logic [NODES-1:0] seen_q, seen_d;

    assign is_loop = seen_q[wr_node] && !is_dup;

    always_comb begin
        seen_d = seen_q;
        if (clr) begin
            seen_d = '0;
        end else if (wr_accept) begin
            seen_d[wr_node] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end
`else
    assign is_loop = 1'b0;
`endif

    assign wr_accept = (state_q == S_CAPTURE) && wr_en && !clr && !is_dup && !is_loop && !is_full;

    always_comb begin
        state_d    = state_q;
        hop_d      = hop_q;
        ovf_d      = ovf_q;
        loop_d     = loop_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_node_d  = rd_node_q;
        rd_last_d  = rd_last_q;

        case (state_q)
            S_CAPTURE: begin
                if (wr_en && !is_dup) begin
                    if (is_loop) begin
                        loop_d = 1'b1;
                    end else if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        hop_d = hop_q + CNT_W'(1);
                    end
                end
                // The decision uses the post-write count so a write alongside trace_done counts.
                if (trace_done) begin
                    state_d = (hop_d != '0) ? S_REPLAY : S_HOLD;
                end
            end
            S_REPLAY: begin
                if (!rd_valid_q) begin
                    rd_ptr_d   = first_idx;
                    rd_node_d  = mem_q[first_idx];
                    rd_last_d  = (hop_q == CNT_W'(1));
                    rd_valid_d = 1'b1;
                end else if (rd_ready) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = S_HOLD;
                    end else begin
                        rd_ptr_d  = next_idx;
                        rd_node_d = mem_q[next_idx];
                        rd_last_d = (rd_ptr_q == PTR_W'(1));
                    end
                end
            end
            default: begin
            end
        endcase

        if (clr) begin
            state_d    = S_CAPTURE;
            hop_d      = '0;
            ovf_d      = 1'b0;
            loop_d     = 1'b0;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b0;
            rd_node_d  = '0;
            rd_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hop_q      <= '0;
            ovf_q      <= 1'b0;
            loop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_node_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hop_q      <= hop_d;
            ovf_q      <= ovf_d;
            loop_q     <= loop_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_node_q  <= rd_node_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Path storage needs no reset: entries beyond hop_q are never read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[hop_q[PTR_W-1:0]] <= wr_node;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_node   = rd_node_q;
    assign rd_last   = rd_last_q;
    assign hop_count = hop_q;
    assign overflow  = ovf_q;
    assign loop_err  = loop_q;
    assign busy      = (state_q == S_CAPTURE) || (state_q == S_REPLAY);

endmodule
